pipe_skid_stage: RTL
====================

// Module: pipe_skid_stage
// PURPOSE
//  Elastic pipeline stage: a 2-entry skid buffer that consumes words from an upstream
//  stage via valid/ready and feeds the plain DFF pipeline register bank downstream.
//  Lets a downstream stall be absorbed without a combinational ready path back upstream.
//  Supports synchronous flush for branch squash. Counts downstream stall cycles for debug.
// PARAMETERS
//  bitz    32  width of data word carried through the stage
//  CNT_W   16  width of saturating stall-cycle counter
// PORTS
//  clk        in   1       single clock; all state updates on posedge
//  reset      in   1       synchronous, active-low reset (0 = reset, sampled on posedge clk)
//  in_valid   in   1       upstream word present on in_data
//  in_ready   out  1       stage can accept a word this cycle
//  in_data    in   bitz    upstream word
//  flush      in   1       squash all held words this cycle
//  out_valid  out  1       out_data holds a valid word
//  out_ready  in   1       downstream accepts out_data this cycle
//  out_data   out  bitz    oldest held word
//  occupancy  out  2       number of held words, 0..2
//  stall_cnt  out  CNT_W   cycles with out_valid=1 && out_ready=0, saturating
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state EMPTY, out_valid=0, in_ready=1, out_data=0,
//    skid reg=0, occupancy=0, stall_cnt=0. Reset overrides flush and all handshakes.
//  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - Storage: main reg (drives out_data) and skid reg. out_data changes only on posedge.
//  - State machine (occupancy = 0/1/2 for EMPTY/ONE/TWO):
//    EMPTY: in_fire -> ONE, main<=in_data; else stay.
//    ONE  : in_fire & out_fire -> ONE, main<=in_data;
//           out_fire only -> EMPTY; in_fire only -> TWO, skid<=in_data; neither -> stay.
//    TWO  : out_fire -> ONE, main<=skid; else stay. in_valid ignored (in_ready=0).
//  - out_valid = (state != EMPTY); in_ready = (state != TWO). Both decoded from state
//    regs only: no combinational path from out_ready or in_valid to either output.
//  - Latency: word accepted at edge N visible on out_data/out_valid after edge N (1 cycle)
//    when stage was EMPTY or main was consumed same edge.
//  - Ordering strictly FIFO; no word duplicated or dropped except by flush.
//  - flush=1 at posedge: state->EMPTY, all held words discarded, any in_fire that cycle
//    also discarded, out_fire that cycle still counts as taken downstream. Data regs
//    need not clear. stall_cnt unaffected by flush.
//  - stall_cnt increments by 1 each posedge where out_valid=1 && out_ready=0 (sampled
//    before update); holds at 2^CNT_W-1; cleared only by reset.
//  - out_ready while out_valid=0 has no effect. in_data is don't-care when in_valid=0.
// TESTING
//  1 Reset: reset=0 two cycles with in_valid=1, in_data=32'hDEAD -> out_valid=0,
//    in_ready=1, occupancy=0, stall_cnt=0 after release.
//  2 Streaming: out_ready=1, send 1,2,3,4 back-to-back -> out_data 1,2,3,4 on
//    consecutive cycles, each 1 cycle after accept, occupancy stays 1, stall_cnt=0.
//  3 Skid: send 5,6 with out_ready=0 -> occupancy=2, in_ready=0, 7 held off;
//    raise out_ready -> 5,6,7 delivered in order, stall_cnt equals stalled cycles.
//  4 Flush: occupancy=2 (8,9), flush=1 with in_valid=1 data 10 -> next cycle
//    out_valid=0, occupancy=0, 10 never appears on out_data.
//  5 Saturation: CNT_W=4, out_ready=0 with one word held for 20 cycles -> stall_cnt
//    reaches 15 and holds; flush does not clear it, reset does.
//  6 Mid-op reset: occupancy=2, assert reset=0 one cycle -> all reset values restored,
//    next word accepted normally with 1-cycle latency.

Source files
------------

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_skid_stage
//  Purpose  : 2-entry skid buffer between valid/ready upstream and a DFF
//             pipeline register, with flush and a saturating stall counter.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_skid_stage #(
  parameter int bitz  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [bitz-1:0]  in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [bitz-1:0]  out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  // Encoding doubles as the held-word count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [bitz-1:0]  main_q, main_d;
  logic [bitz-1:0]  skid_q, skid_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             in_fire;
  logic             out_fire;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != TWO);
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    stall_d = stall_q;

    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        case ({in_fire, out_fire})
          2'b11: main_d = in_data;
          2'b01: state_d = EMPTY;
          2'b10: begin
            state_d = TWO;
            skid_d  = in_data;
          end
          default: ;
        endcase
      end
      TWO: begin
        if (out_fire) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Squash wins over any accept this cycle; the data regs may keep stale words.
    if (flush) state_d = EMPTY;

    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

endmodule
`default_nettype wire
